rtc_port_writer: RTL and testbench

Register-update initiator for the port-mapped display interface. Captures a snapshot of the RTC date, time, timer and cursor fields and replays them as single-cycle `WRITE_STROBE` / `PORT_ID` / `OUT_PORT` writes, in the format consumed by the VGA display register bank. The block sits between the RTC read-out logic and the VGA top. It sends either every field or only the fields that changed since the last write.

---
 rtl/rtc_port_pkg.sv | 57 +++++
 rtl/rtc_port_writer.sv | 182 ++++++++++++++++++
 tb/tb_rtc_port_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_port_pkg.sv
// rtc_port_pkg
// Shared definitions for the RTC-to-display port writer: field indices,
// display port IDs (also decoded by the VGA display register bank) and the
// writer FSM encoding.
package rtc_port_pkg;

  localparam int NUM_FIELDS = 10;

  localparam logic [3:0] IDX_SEG     = 4'd0;
  localparam logic [3:0] IDX_MIN     = 4'd1;
  localparam logic [3:0] IDX_HORA    = 4'd2;
  localparam logic [3:0] IDX_DIA     = 4'd3;
  localparam logic [3:0] IDX_MES     = 4'd4;
  localparam logic [3:0] IDX_ANO     = 4'd5;
  localparam logic [3:0] IDX_SEGT    = 4'd6;
  localparam logic [3:0] IDX_MINT    = 4'd7;
  localparam logic [3:0] IDX_HORAT   = 4'd8;
  localparam logic [3:0] IDX_PUNTERO = 4'd9;

  localparam logic [7:0] PORT_SEG     = 8'h02;
  localparam logic [7:0] PORT_MIN     = 8'h03;
  localparam logic [7:0] PORT_HORA    = 8'h04;
  localparam logic [7:0] PORT_DIA     = 8'h05;
  localparam logic [7:0] PORT_MES     = 8'h06;
  localparam logic [7:0] PORT_ANO     = 8'h07;
  localparam logic [7:0] PORT_SEGT    = 8'h08;
  localparam logic [7:0] PORT_MINT    = 8'h09;
  localparam logic [7:0] PORT_HORAT   = 8'h0A;
  localparam logic [7:0] PORT_PUNTERO = 8'h0E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE,
    ST_WAIT,
    ST_FIN
  } state_t;

  function automatic logic [7:0] port_of(input logic [3:0] idx);
    logic [7:0] p;
    case (idx)
      IDX_SEG:     p = PORT_SEG;
      IDX_MIN:     p = PORT_MIN;
      IDX_HORA:    p = PORT_HORA;
      IDX_DIA:     p = PORT_DIA;
      IDX_MES:     p = PORT_MES;
      IDX_ANO:     p = PORT_ANO;
      IDX_SEGT:    p = PORT_SEGT;
      IDX_MINT:    p = PORT_MINT;
      IDX_HORAT:   p = PORT_HORAT;
      IDX_PUNTERO: p = PORT_PUNTERO;
      default:     p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_port_writer.sv
// rtc_port_writer
// Snapshots the RTC date/time/timer/cursor fields on LOAD and replays them
// as single-cycle port writes for the VGA display register bank. Either all
// fields are sent, or only those that differ from the last value written.
//
// Ports:
//   CLK, RST                 clock, async active-high reset
//   LOAD, FULL_REFRESH       transfer request and its mode
//   SEG..PUNTERO             field inputs, captured on LOAD
//   WRITE_STROBE, PORT_ID,
//   OUT_PORT                 port write bus (ID/data hold between strobes)
//   BUSY, DONE               transfer in progress / completion pulse
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for LOAD
// ST_SCAN  | decide whether field idx must be written
// ST_WRITE | strobe field idx, update its shadow
// ST_WAIT  | GAP idle cycles after a strobe
// ST_FIN   | pulse DONE, mark shadows valid
module rtc_port_writer
  import rtc_port_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic       FULL_REFRESH,
  input  logic [7:0] SEG,
  input  logic [7:0] MIN,
  input  logic [7:0] HORA,
  input  logic [7:0] DIA,
  input  logic [7:0] MES,
  input  logic [7:0] ANO,
  input  logic [7:0] SEGT,
  input  logic [7:0] MINT,
  input  logic [7:0] HORAT,
  input  logic [7:0] PUNTERO,
  output logic       WRITE_STROBE,
  output logic [7:0] PORT_ID,
  output logic [7:0] OUT_PORT,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [3:0] GAP_L   = 4'(GAP);
  localparam logic [3:0] IDX_LAST = 4'(NUM_FIELDS - 1);

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic [7:0] snap   [NUM_FIELDS];
  logic [7:0] shadow [NUM_FIELDS];
  logic [7:0] fields_in [NUM_FIELDS];
  logic       shadow_valid;
  logic       full_mode;
  logic       capture;
  logic       shadow_we;
  logic       field_due;
  logic       last_field;

  always_comb begin
    fields_in[IDX_SEG]     = SEG;
    fields_in[IDX_MIN]     = MIN;
    fields_in[IDX_HORA]    = HORA;
    fields_in[IDX_DIA]     = DIA;
    fields_in[IDX_MES]     = MES;
    fields_in[IDX_ANO]     = ANO;
    fields_in[IDX_SEGT]    = SEGT;
    fields_in[IDX_MINT]    = MINT;
    fields_in[IDX_HORAT]   = HORAT;
    fields_in[IDX_PUNTERO] = PUNTERO;
  end

  assign field_due  = full_mode || (snap[idx] != shadow[idx]);
  assign last_field = (idx == IDX_LAST);

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_cnt_nxt = gap_cnt;
    capture     = 1'b0;
    shadow_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (LOAD) begin
          capture   = 1'b1;
          idx_nxt   = 4'd0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (field_due) begin
          state_nxt = ST_WRITE;
        end else if (last_field) begin
          state_nxt = ST_FIN;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      ST_WRITE: begin
        shadow_we = 1'b1;
        if (GAP_L != 4'd0) begin
          gap_cnt_nxt = GAP_L;
          state_nxt   = ST_WAIT;
        end else if (last_field) begin
          state_nxt = ST_FIN;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = ST_SCAN;
        end
      end
      ST_WAIT: begin
        gap_cnt_nxt = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) begin
          if (last_field) begin
            state_nxt = ST_FIN;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // A missing shadow set forces a full refresh regardless of FULL_REFRESH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        snap[i]   <= 8'h00;
        shadow[i] <= 8'h00;
      end
      shadow_valid <= 1'b0;
      full_mode    <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < NUM_FIELDS; i++) snap[i] <= fields_in[i];
        full_mode <= FULL_REFRESH || !shadow_valid;
      end
      if (shadow_we) shadow[idx] <= snap[idx];
      if (state == ST_FIN) shadow_valid <= 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WRITE_STROBE <= 1'b0;
      PORT_ID      <= 8'h00;
      OUT_PORT     <= 8'h00;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      WRITE_STROBE <= (state_nxt == ST_WRITE);
      if (state_nxt == ST_WRITE) begin
        PORT_ID  <= port_of(idx_nxt);
        OUT_PORT <= snap[idx_nxt];
      end
      BUSY <= (state_nxt == ST_SCAN) || (state_nxt == ST_WRITE) ||
              (state_nxt == ST_WAIT);
      DONE <= (state_nxt == ST_FIN);
    end
  end

endmodule

// File: tb/tb_rtc_port_writer.sv
module tb_rtc_port_writer;

  typedef struct {
    int         cyc;
    logic [7:0] port;
    logic [7:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD;
  logic       FULL_REFRESH;
  logic [7:0] f [10];

  logic       ws1, busy1, done1, ws0, busy0, done0;
  logic [7:0] pid1, op1, pid0, op0;

  bit         sel_gap0;
  logic       ws, busy, done;
  logic [7:0] pid, op;

  exp_t       sb[$];
  logic [7:0] m_shadow [10];
  bit         m_valid;
  int         done_cyc;
  logic [7:0] last_port, last_data;
  int         n_chk, n_fail;

  always #5 CLK = ~CLK;

  rtc_port_writer #(.GAP(1)) u_gap1 (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .FULL_REFRESH(FULL_REFRESH),
    .SEG(f[0]), .MIN(f[1]), .HORA(f[2]), .DIA(f[3]), .MES(f[4]),
    .ANO(f[5]), .SEGT(f[6]), .MINT(f[7]), .HORAT(f[8]), .PUNTERO(f[9]),
    .WRITE_STROBE(ws1), .PORT_ID(pid1), .OUT_PORT(op1),
    .BUSY(busy1), .DONE(done1)
  );

  rtc_port_writer #(.GAP(0)) u_gap0 (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .FULL_REFRESH(FULL_REFRESH),
    .SEG(f[0]), .MIN(f[1]), .HORA(f[2]), .DIA(f[3]), .MES(f[4]),
    .ANO(f[5]), .SEGT(f[6]), .MINT(f[7]), .HORAT(f[8]), .PUNTERO(f[9]),
    .WRITE_STROBE(ws0), .PORT_ID(pid0), .OUT_PORT(op0),
    .BUSY(busy0), .DONE(done0)
  );

  assign ws   = sel_gap0 ? ws0   : ws1;
  assign pid  = sel_gap0 ? pid0  : pid1;
  assign op   = sel_gap0 ? op0   : op1;
  assign busy = sel_gap0 ? busy0 : busy1;
  assign done = sel_gap0 ? done0 : done1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] port_tbl(input int i);
    case (i)
      0: return 8'h02;
      1: return 8'h03;
      2: return 8'h04;
      3: return 8'h05;
      4: return 8'h06;
      5: return 8'h07;
      6: return 8'h08;
      7: return 8'h09;
      8: return 8'h0A;
      9: return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // Cycle 1 is the first SCAN; a written field takes WRITE + gap + next SCAN.
  task automatic push_model(input bit full, input int gap);
    int c;
    bit fm;
    exp_t e;
    fm = full || !m_valid;
    c = 1;
    for (int i = 0; i < 10; i++) begin
      if (fm || f[i] != m_shadow[i]) begin
        e.cyc = c + 1; e.port = port_tbl(i); e.data = f[i];
        sb.push_back(e);
        m_shadow[i] = f[i];
        c += 2 + gap;
      end else begin
        c += 1;
      end
    end
    done_cyc = c;
    m_valid = 1'b1;
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 10; i++) m_shadow[i] = 8'h00;
    m_valid   = 1'b0;
    last_port = 8'h00;
    last_data = 8'h00;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_strobe"}, 32'(ws), 0);
    chk({tag, "_port_id"}, 32'(pid), 0);
    chk({tag, "_out_port"}, 32'(op), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic xfer(input bit full, input int hora_cyc, input int reload_cyc, input int rst_cyc);
    exp_t e;
    @(negedge CLK);
    LOAD = 1'b1;
    FULL_REFRESH = full;
    push_model(full, sel_gap0 ? 0 : 1);
    for (int k = 1; k <= done_cyc + 2; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        LOAD = 1'b0;
        FULL_REFRESH = 1'b0;
      end
      if (ws) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe_cycle", 32'(k), 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", 32'(k), 32'(e.cyc));
          chk("port_id", 32'(pid), 32'(e.port));
          chk("out_port", 32'(op), 32'(e.data));
          last_port = e.port;
          last_data = e.data;
        end
      end else begin
        chk("port_id_hold", 32'(pid), 32'(last_port));
        chk("out_port_hold", 32'(op), 32'(last_data));
      end
      chk("busy", 32'(busy), 32'(k < done_cyc));
      chk("done", 32'(done), 32'(k == done_cyc));
      if (k == hora_cyc) f[2] = 8'h11;
      if (k == reload_cyc) begin
        LOAD = 1'b1;
        FULL_REFRESH = 1'b1;
      end
      if (k == reload_cyc + 1) begin
        LOAD = 1'b0;
        FULL_REFRESH = 1'b0;
      end
      if (k == rst_cyc) begin
        RST = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
    end
    chk("pending_strobes", 32'(sb.size()), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    sel_gap0 = 1'b0;
    LOAD = 1'b0;
    FULL_REFRESH = 1'b0;
    f = '{8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24, 8'h10, 8'h05, 8'h01, 8'h03};
    model_reset();
    RST = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_outputs_zero("post_reset");

    // First LOAD after reset is full even with FULL_REFRESH=0.
    xfer(1'b0, -1, -100, -1);

    // Only MIN changes.
    f[1] = 8'h00;
    xfer(1'b0, -1, -100, -1);

    // Nothing changes: no strobes, DONE still pulses.
    xfer(1'b0, -1, -100, -1);

    // Full refresh; LOAD re-pulsed mid-transfer, HORA input changed after capture.
    xfer(1'b1, 3, 5, -1);

    // Delta picks up the HORA change made after the previous capture.
    xfer(1'b0, -1, -100, -1);

    // Reset mid-transfer, then a delta request must send everything.
    f[4] = 8'h07;
    f[9] = 8'h1C;
    xfer(1'b1, -1, -100, 8);
    xfer(1'b0, -1, -100, -1);

    // GAP=0 instance, full refresh with fresh data.
    sel_gap0 = 1'b1;
    for (int i = 0; i < 10; i++) f[i] = 8'($urandom_range(0, 255));
    xfer(1'b1, -1, -100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
